// File: rtl/sat_chan_sched_pkg.sv
// Shared types for the satellite channel config scheduler.
// Field addresses, commit FSM states and per-channel config record.
package sat_chan_sched_pkg;

  localparam logic [2:0] ADDR_DOP   = 3'd0;
  localparam logic [2:0] ADDR_CODE  = 3'd1;
  localparam logic [2:0] ADDR_GAIN  = 3'd2;
  localparam logic [2:0] ADDR_CA    = 3'd3;
  localparam logic [2:0] ADDR_DRATE = 3'd4;
  localparam logic [2:0] ADDR_CRATE = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    APPLY
  } state_t;

  typedef struct packed {
    logic [31:0] dop_freq;
    logic [31:0] code_freq;
    logic [31:0] dop_rate;
    logic [31:0] code_rate;
    logic [15:0] gain;
    logic [5:0]  ca_sel;
    logic        en;
  } chan_cfg_t;

endpackage

// File: rtl/sat_chan_sched_epoch.sv
// Epoch counter in dv_in samples with wrap strobe and registered tick.
// wrap is combinational so the commit logic can act on the same edge.
module sat_chan_sched_epoch #(
  parameter int EPOCH_LEN = 16368
) (
  input  logic clk,
  input  logic reset,
  input  logic dv_in,
  output logic wrap,
  output logic epoch_tick
);

  localparam int CW = (EPOCH_LEN > 1) ? $clog2(EPOCH_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(EPOCH_LEN - 1);

  logic [CW-1:0] count;

  assign wrap = dv_in && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      epoch_tick <= 1'b0;
    end else begin
      epoch_tick <= wrap;
      if (wrap)
        count <= '0;
      else if (dv_in)
        count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/sat_chan_sched.sv
// Shadow/active channel config banks with epoch-aligned atomic commit.
// Optional SAT_CHAN_SCHED_RAMP_EN adds per-epoch NCO frequency ramping.
module sat_chan_sched #(
  parameter int NCHAN     = 8,
  parameter int EPOCH_LEN = 16368
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dv_in,
  input  logic              wr_en,
  input  logic [3:0]        wr_chan,
  input  logic [2:0]        wr_addr,
  input  logic [31:0]       wr_data,
  input  logic              commit_req,
  output logic              commit_busy,
  output logic              commit_done,
  output logic              epoch_tick,
  output logic [NCHAN*32-1:0] dop_freq,
  output logic [NCHAN*32-1:0] code_freq,
  output logic [NCHAN*16-1:0] gain,
  output logic [NCHAN*6-1:0]  ca_sel,
  output logic [NCHAN-1:0]    chan_en
);

  import sat_chan_sched_pkg::*;

  state_t    state;
  logic      wrap;
  logic      load;
  chan_cfg_t shadow [NCHAN];
  chan_cfg_t active [NCHAN];

  sat_chan_sched_epoch #(
    .EPOCH_LEN (EPOCH_LEN)
  ) u_epoch (
    .clk        (clk),
    .reset      (reset),
    .dv_in      (dv_in),
    .wrap       (wrap),
    .epoch_tick (epoch_tick)
  );

  // Copy happens on the wrap edge so new values land with epoch_tick.
  assign load = (state == ARMED) && wrap;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      commit_busy <= 1'b0;
      commit_done <= 1'b0;
    end else begin
      commit_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (commit_req) begin
            state       <= ARMED;
            commit_busy <= 1'b1;
          end
        end
        ARMED: begin
          if (wrap) begin
            state       <= APPLY;
            commit_busy <= 1'b0;
            commit_done <= 1'b1;
          end
        end
        APPLY: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCHAN; i++)
        shadow[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NCHAN; i++) begin
        if (wr_chan == 4'(i)) begin
          case (wr_addr)
            ADDR_DOP:  shadow[i].dop_freq  <= wr_data;
            ADDR_CODE: shadow[i].code_freq <= wr_data;
            ADDR_GAIN: shadow[i].gain      <= wr_data[15:0];
            ADDR_CA: begin
              shadow[i].en     <= wr_data[8];
              shadow[i].ca_sel <= wr_data[5:0];
            end
`ifdef SAT_CHAN_SCHED_RAMP_EN
            ADDR_DRATE: shadow[i].dop_rate  <= wr_data;
            ADDR_CRATE: shadow[i].code_rate <= wr_data;
`endif
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCHAN; i++)
        active[i] <= '0;
    end else begin
      for (int i = 0; i < NCHAN; i++) begin
        if (load) begin
          active[i] <= shadow[i];
`ifdef SAT_CHAN_SCHED_RAMP_EN
        end else if (wrap) begin
          active[i].dop_freq  <= active[i].dop_freq
                               + active[i].dop_rate;
          active[i].code_freq <= active[i].code_freq
                               + active[i].code_rate;
`endif
        end
      end
    end
  end

  always_comb begin
    dop_freq  = '0;
    code_freq = '0;
    gain      = '0;
    ca_sel    = '0;
    chan_en   = '0;
    for (int i = 0; i < NCHAN; i++) begin
      dop_freq[32*i +: 32]  = active[i].dop_freq;
      code_freq[32*i +: 32] = active[i].code_freq;
      gain[16*i +: 16]      = active[i].en ? active[i].gain : 16'h0;
      ca_sel[6*i +: 6]      = active[i].ca_sel;
      chan_en[i]            = active[i].en;
    end
  end

endmodule

// File: tb/tb_sat_chan_sched.sv
// Scoreboard bench for sat_chan_sched (NCHAN=8, EPOCH_LEN=16).
// Expected banks are queued at commit time and checked on commit_done.
module tb_sat_chan_sched;

  localparam int NCH  = 8;
  localparam int ELEN = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dv_in = 1'b1;
  logic wr_en = 1'b0;
  logic [3:0] wr_chan = '0;
  logic [2:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic commit_req = 1'b0;
  logic commit_busy, commit_done, epoch_tick;
  logic [NCH*32-1:0] dop_freq, code_freq;
  logic [NCH*16-1:0] gain;
  logic [NCH*6-1:0] ca_sel;
  logic [NCH-1:0] chan_en;

  sat_chan_sched #(.NCHAN(NCH), .EPOCH_LEN(ELEN)) dut (
    .clk         (clk),
    .reset       (reset),
    .dv_in       (dv_in),
    .wr_en       (wr_en),
    .wr_chan     (wr_chan),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .commit_req  (commit_req),
    .commit_busy (commit_busy),
    .commit_done (commit_done),
    .epoch_tick  (epoch_tick),
    .dop_freq    (dop_freq),
    .code_freq   (code_freq),
    .gain        (gain),
    .ca_sel      (ca_sel),
    .chan_en     (chan_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCH*32-1:0] dop;
    logic [NCH*32-1:0] code;
    logic [NCH*16-1:0] gain;
    logic [NCH*6-1:0]  ca;
    logic [NCH-1:0]    en;
  } snap_t;

  snap_t exp_q[$];
  int errors = 0;
  int checks = 0;

  logic [31:0] m_dop [16];
  logic [31:0] m_code [16];
  logic [31:0] m_drate [16];
  logic [31:0] m_crate [16];
  logic [15:0] m_gain [16];
  logic [5:0]  m_ca [16];
  logic        m_en [16];

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic snap_t snap();
    snap_t s;
    for (int i = 0; i < NCH; i++) begin
      s.dop[32*i +: 32]  = m_dop[i];
      s.code[32*i +: 32] = m_code[i];
      s.gain[16*i +: 16] = m_en[i] ? m_gain[i] : 16'h0;
      s.ca[6*i +: 6]     = m_ca[i];
      s.en[i]            = m_en[i];
    end
    return s;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 16; i++) begin
      m_dop[i] = '0; m_code[i] = '0;
      m_drate[i] = '0; m_crate[i] = '0;
      m_gain[i] = '0; m_ca[i] = '0; m_en[i] = 1'b0;
    end
  endtask

  task automatic wr(input int ch, input int addr, input logic [31:0] d);
    wr_en = 1'b1;
    wr_chan = 4'(ch);
    wr_addr = 3'(addr);
    wr_data = d;
    if (ch < NCH) begin
      case (addr)
        0: m_dop[ch] = d;
        1: m_code[ch] = d;
        2: m_gain[ch] = d[15:0];
        3: begin m_en[ch] = d[8]; m_ca[ch] = d[5:0]; end
`ifdef SAT_CHAN_SCHED_RAMP_EN
        4: m_drate[ch] = d;
        5: m_crate[ch] = d;
`endif
        default: ;
      endcase
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_commit();
    commit_req = 1'b1;
    @(negedge clk);
    commit_req = 1'b0;
  endtask

  task automatic wait_tick();
    bit seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (epoch_tick) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL wait_tick: no epoch_tick within 40 cycles");
    end
  endtask

  int cyc = 0;
  int last_tick = -1;
  snap_t ms;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      last_tick = -1;
    end else begin
      if (epoch_tick) begin
        if (last_tick >= 0)
          chk("tick_period", 256'(cyc - last_tick), 256'(ELEN));
        last_tick = cyc;
      end
      if (commit_done) begin
        chk("done_with_tick", 256'(epoch_tick), 256'(1));
        chk("busy_low_at_done", 256'(commit_busy), 256'(0));
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_commit_done: got pulse at cycle %0d expected none", cyc);
        end else begin
          ms = exp_q.pop_front();
          chk("sb_dop", 256'(dop_freq), 256'(ms.dop));
          chk("sb_code", 256'(code_freq), 256'(ms.code));
          chk("sb_gain", 256'(gain), 256'(ms.gain));
          chk("sb_ca", 256'(ca_sel), 256'(ms.ca));
          chk("sb_en", 256'(chan_en), 256'(ms.en));
        end
      end
    end
  end

  initial begin
    clear_model();
    repeat (3) @(negedge clk);
    chk("rst_busy", 256'(commit_busy), 256'(0));
    chk("rst_done", 256'(commit_done), 256'(0));
    chk("rst_tick", 256'(epoch_tick), 256'(0));
    chk("rst_dop", 256'(dop_freq), 256'(0));
    chk("rst_gain", 256'(gain), 256'(0));
    chk("rst_en", 256'(chan_en), 256'(0));
    reset = 1'b0;
    wait_tick();
    chk("idle_dop", 256'(dop_freq), 256'(0));
    chk("idle_busy", 256'(commit_busy), 256'(0));

    // basic commit, request at count 3
    wr(2, 0, 32'h0010_0000);
    wr(2, 2, 32'hDEAD_4000);
    wr(2, 3, 32'hABCD_0105);
    pulse_commit();
    chk("armed_busy", 256'(commit_busy), 256'(1));
    chk("armed_hold_dop", 256'(dop_freq[64 +: 32]), 256'(0));
    exp_q.push_back(snap());
    wait_tick();
    chk("ch2_dop", 256'(dop_freq[64 +: 32]), 256'(32'h0010_0000));
    chk("ch2_gain", 256'(gain[32 +: 16]), 256'(16'h4000));
    chk("ch2_ca", 256'(ca_sel[12 +: 6]), 256'(5));
    chk("ch2_en", 256'(chan_en[2]), 256'(1));

    // second request while armed, writes while armed
    pulse_commit();
    wr(1, 0, 32'h0000_1234);
    pulse_commit();
    wr(1, 1, 32'h0000_0777);
    exp_q.push_back(snap());
    wait_tick();
    chk("ch1_dop", 256'(dop_freq[32 +: 32]), 256'(32'h1234));
    chk("ch1_code", 256'(code_freq[32 +: 32]), 256'(32'h777));
    wr(1, 0, 32'h0000_5678);
    chk("single_done", 256'(commit_done), 256'(0));
    repeat (14) @(negedge clk);
    commit_req = 1'b1;
    @(negedge clk);
    commit_req = 1'b0;
    chk("wrap_req_tick", 256'(epoch_tick), 256'(1));
    chk("wrap_req_no_done", 256'(commit_done), 256'(0));
    chk("wrap_req_busy", 256'(commit_busy), 256'(1));
    chk("wrap_req_hold", 256'(dop_freq[32 +: 32]), 256'(32'h1234));
    exp_q.push_back(snap());
    wait_tick();
    chk("wrap_req_dop", 256'(dop_freq[32 +: 32]), 256'(32'h5678));

    // shadow write and ignored request in the APPLY cycle
    wr(3, 2, 32'h0000_2222);
    wr(3, 3, 32'h0000_0100);
    pulse_commit();
    exp_q.push_back(snap());
    wait_tick();
    commit_req = 1'b1;
    wr(3, 2, 32'h0000_1111);
    commit_req = 1'b0;
    chk("apply_req_ignored", 256'(commit_busy), 256'(0));
    chk("apply_wr_gain", 256'(gain[48 +: 16]), 256'(16'h2222));
    pulse_commit();
    exp_q.push_back(snap());
    wait_tick();
    chk("next_gain", 256'(gain[48 +: 16]), 256'(16'h1111));

    // ignored writes and gain masking
    wr(8, 0, 32'hBAD0_BAD0);
    wr(3, 7, 32'hFFFF_FFFF);
    wr(3, 6, 32'hFFFF_FFFF);
    wr(4, 2, 32'h0000_7FFF);
    wr(4, 3, 32'h0000_003F);
    pulse_commit();
    exp_q.push_back(snap());
    wait_tick();
    chk("ch0_dop", 256'(dop_freq[0 +: 32]), 256'(0));
    chk("ch3_ca", 256'(ca_sel[18 +: 6]), 256'(0));
    chk("ch3_gain", 256'(gain[48 +: 16]), 256'(16'h1111));
    chk("ch4_gain_masked", 256'(gain[64 +: 16]), 256'(0));
    chk("ch4_ca", 256'(ca_sel[24 +: 6]), 256'(6'h3F));
    chk("ch4_en", 256'(chan_en[4]), 256'(0));

    // rate registers
    wr(5, 0, 32'hFFFF_FFF0);
    wr(5, 1, 32'h0000_0100);
    wr(5, 4, 32'h0000_0020);
    wr(5, 5, 32'hFFFF_FFFF);
    pulse_commit();
    exp_q.push_back(snap());
    wait_tick();
    chk("ramp_apply_dop", 256'(dop_freq[160 +: 32]), 256'(32'hFFFF_FFF0));
    wait_tick();
`ifdef SAT_CHAN_SCHED_RAMP_EN
    chk("ramp1_dop", 256'(dop_freq[160 +: 32]), 256'(32'h0000_0010));
    chk("ramp1_code", 256'(code_freq[160 +: 32]), 256'(32'h0000_00FF));
    wait_tick();
    chk("ramp2_dop", 256'(dop_freq[160 +: 32]), 256'(32'h0000_0030));
    chk("ramp2_code", 256'(code_freq[160 +: 32]), 256'(32'h0000_00FE));
`else
    chk("noramp1_dop", 256'(dop_freq[160 +: 32]), 256'(32'hFFFF_FFF0));
    chk("noramp1_code", 256'(code_freq[160 +: 32]), 256'(32'h0000_0100));
    wait_tick();
    chk("noramp2_dop", 256'(dop_freq[160 +: 32]), 256'(32'hFFFF_FFF0));
`endif

    // reset while armed abandons the commit
    pulse_commit();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_busy", 256'(commit_busy), 256'(0));
    chk("mid_rst_done", 256'(commit_done), 256'(0));
    chk("mid_rst_dop", 256'(dop_freq), 256'(0));
    chk("mid_rst_code", 256'(code_freq), 256'(0));
    chk("mid_rst_gain", 256'(gain), 256'(0));
    chk("mid_rst_ca", 256'(ca_sel), 256'(0));
    chk("mid_rst_en", 256'(chan_en), 256'(0));
    reset = 1'b0;
    clear_model();
    wait_tick();
    wait_tick();
    chk("post_rst_busy", 256'(commit_busy), 256'(0));
    pulse_commit();
    exp_q.push_back(snap());
    wait_tick();

    repeat (2) @(negedge clk);
    chk("queue_empty", 256'(exp_q.size()), 256'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sat_chan_sched.md
Name: sat_chan_sched

Overview:
Configuration scheduler for a bank of NCHAN satellite channel generators. The host writes per-channel Doppler NCO word, code NCO word, gain, C/A select and enable into a shadow bank. A commit request is applied atomically to the active bank on the next 1 ms epoch boundary, counted in dv_in samples, so all channels retune together without mid-chip glitches. Sits between the host register interface and the channel generator array feeding the noise combiner.

Parameters:
NCHAN, 8, number of satellite channels driven (1..16)
EPOCH_LEN, 16368, dv_in samples per epoch (1 ms at Fs = 16.368 MHz)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
dv_in  in  1  sample strobe; the epoch counter advances only on dv_in
wr_en  in  1  host shadow-register write strobe
wr_chan  in  4  target channel index
wr_addr  in  3  field select: 0 dop_freq, 1 code_freq, 2 gain[15:0], 3 {en[8], ca_sel[5:0]}, 4 dop_rate, 5 code_rate
wr_data  in  32  write data
commit_req  in  1  one-cycle pulse; arms a commit for the next epoch
commit_busy  out  1  high from accepted commit_req until the commit is applied
commit_done  out  1  one-cycle pulse on the cycle the active bank updates
epoch_tick  out  1  one-cycle pulse at every epoch wrap
dop_freq  out  NCHAN*32  active Doppler NCO words, channel i at [32i+:32]
code_freq  out  NCHAN*32  active code NCO words
gain  out  NCHAN*16  active gains; a disabled channel drives 0
ca_sel  out  NCHAN*6  active C/A PRN selects
chan_en  out  NCHAN  active channel enables

Behaviour:
- Reset: epoch counter 0; state IDLE; shadow and active banks all zero; all outputs 0; commit_busy, commit_done and epoch_tick are 0.
- Epoch counter: 0..EPOCH_LEN-1, increments on dv_in. A dv_in at count EPOCH_LEN-1 wraps the counter to 0 and asserts epoch_tick on the next cycle (registered, 1-cycle latency).
- Host writes: on wr_en, the addressed shadow field updates on the next edge.
  - Writes with wr_chan >= NCHAN are ignored.
  - Writes to wr_addr 6 or 7 are ignored.
  - For addr 2, only wr_data[15:0] is used; for addr 3, only bits [8] and [5:0] are used.
- Commit FSM:
  - IDLE: commit_req moves to ARMED; commit_busy goes high the next cycle.
  - ARMED: on the epoch wrap condition (dv_in && count == EPOCH_LEN-1), move to APPLY.
  - APPLY (1 cycle): copy the whole shadow bank to the active bank, pulse commit_done, return to IDLE, drop commit_busy.
- Latency: active outputs change in the same cycle as epoch_tick and commit_done.
- commit_req while ARMED or APPLY is ignored and not queued.
- commit_req coinciding with an epoch wrap while IDLE arms for the following epoch, not the current one.
- A shadow write in the same cycle as APPLY: the copy takes the pre-write shadow value; the new value stays in the shadow bank for the next commit.
- Shadow writes while ARMED are allowed, and the latest values at APPLY are committed.
- gain output is masked to 0 when chan_en is 0.
- Reset asserted mid-ARMED abandons the commit and clears everything; no commit_done is issued.

Optional Feature:
Macro SAT_CHAN_SCHED_RAMP_EN.
- Defined: per-channel shadow and active dop_rate and code_rate registers (32-bit, two's complement). On every epoch wrap that is not an APPLY cycle, active dop_freq += dop_rate and code_freq += code_rate, modulo 2^32. The rate registers commit with the rest of the bank. On an APPLY cycle the loaded values are used unramped.
- Not defined: no rate storage; writes to addr 4 and 5 are ignored; active words change only on commit.

Decomposition:
- Package sat_chan_sched_pkg:
  - field address constants (ADDR_DOP, ADDR_CODE, ADDR_GAIN, ADDR_CA, ADDR_DRATE, ADDR_CRATE)
  - state enum (IDLE, ARMED, APPLY)
  - chan_cfg_t struct {dop_freq, code_freq, dop_rate, code_rate, gain, ca_sel, en}
- Sub-module sat_chan_sched_epoch: epoch counter plus wrap/epoch_tick generation. The bank and FSM stay in the top module.

Test Plan:
- Reset, then EPOCH_LEN=16 with dv_in always high -> epoch_tick pulses every 16 cycles; all outputs 0; commit_busy 0.
- Write ch2 dop_freq=0x0010_0000, gain=0x4000, {en=1, ca_sel=5}; commit_req at count 3 -> commit_busy high; outputs unchanged until the wrap; at epoch_tick, ch2 shows the values, commit_done pulses once, commit_busy drops.
- Second commit_req while ARMED -> exactly one commit_done; commit_req on the wrap cycle -> applies one epoch later.
- Shadow write gain=0x1111 in the APPLY cycle, with prior shadow 0x2222 -> active=0x2222; the next commit yields 0x1111.
- wr_chan=NCHAN, and wr_addr=7 -> no register changes; ch with en=0 and gain=0x7FFF -> gain output 0; reset during ARMED -> no commit_done, banks zero.
- RAMP_EN: commit dop_freq=0xFFFF_FFF0, dop_rate=0x20 -> after APPLY the value is unchanged; the next epoch gives 0x0000_0010 (wrap), then 0x30.
